// File: rtl/nios_project_nios2_gen2_0_cpu_debug_mem_access.sv
// Debug monitor RAM access engine: turns debug-slave strobes into RAM reads/writes
// and arbitrates them against CPU accesses to the same single-port RAM.
module nios_project_nios2_gen2_0_cpu_debug_mem_access #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [2:0] {IDLE, JRD, JCAP, JWR, CRD, CRDY, CWR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   monAReg_q, monAReg_d;
  logic [DATA_W-1:0]   monDReg_q, monDReg_d;
  logic                ready_q, ready_d;
  logic                error_q, error_d;
  logic                pendValid_q, pendValid_d;
  logic                pendWrite_q, pendWrite_d;
  logic [DATA_W-1:0]   pendData_q, pendData_d;
  logic [DATA_W-1:0]   ramRdata_q;
  logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];

  logic [ADDR_W-1:0]   ramAddr;
  logic                ramWe;
  logic [DATA_W-1:0]   ramWdata;
  logic                busy, anyStrobe, accept, lowerDrop;
  logic                unusedJdo;

  assign unusedJdo = ^jdo[36:DATA_W];

  assign busy      = pendValid_q || (state_q != IDLE);
  assign anyStrobe = take_action_ocimem_a || take_action_ocimem_b || take_no_action_ocimem_a;
  assign accept    = anyStrobe && !busy;
  assign lowerDrop = (take_action_ocimem_a && (take_action_ocimem_b || take_no_action_ocimem_a)) ||
                     (take_action_ocimem_b && take_no_action_ocimem_a);

  // RAM contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (ramWe) mem[ramAddr] <= ramWdata;
    ramRdata_q <= mem[ramAddr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      monAReg_q   <= '0;
      monDReg_q   <= '0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
      pendValid_q <= 1'b0;
      pendWrite_q <= 1'b0;
      pendData_q  <= '0;
    end else begin
      state_q     <= state_d;
      monAReg_q   <= monAReg_d;
      monDReg_q   <= monDReg_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
      pendValid_q <= pendValid_d;
      pendWrite_q <= pendWrite_d;
      pendData_q  <= pendData_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    monAReg_d   = monAReg_q;
    monDReg_d   = monDReg_q;
    ready_d     = ready_q;
    error_d     = error_q;
    pendValid_d = pendValid_q;
    pendWrite_d = pendWrite_q;
    pendData_d  = pendData_q;
    ramAddr     = monAReg_q;
    ramWe       = 1'b0;
    ramWdata    = pendData_q;

    case (state_q)
      IDLE: begin
        if (pendValid_q)    state_d = pendWrite_q ? JWR : JRD;
        else if (cpu_write) state_d = CWR;
        else if (cpu_read)  state_d = CRD;
      end
      JRD:  state_d = JCAP;
      JCAP: begin
        monDReg_d   = ramRdata_q;
        monAReg_d   = monAReg_q + ADDR_W'(1);
        ready_d     = 1'b1;
        pendValid_d = 1'b0;
        state_d     = IDLE;
      end
      JWR: begin
        ramWe       = 1'b1;
        monAReg_d   = monAReg_q + ADDR_W'(1);
        ready_d     = 1'b1;
        pendValid_d = 1'b0;
        state_d     = IDLE;
      end
      CRD: begin
        ramAddr = cpu_address;
        state_d = CRDY;
      end
      CRDY: state_d = IDLE;
      CWR: begin
        ramAddr  = cpu_address;
        ramWe    = 1'b1;
        ramWdata = cpu_writedata;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are only taken with an empty slot and an idle engine; a drop wins over a clear.
    if (accept) begin
      ready_d = 1'b0;
      if (take_action_ocimem_a) begin
        monAReg_d = jdo[ADDR_W+1:2];
        error_d   = 1'b0;
        if (jdo[37]) begin
          pendValid_d = 1'b1;
          pendWrite_d = 1'b0;
        end
      end else if (take_action_ocimem_b) begin
        pendValid_d = 1'b1;
        pendWrite_d = 1'b1;
        pendData_d  = jdo[DATA_W-1:0];
      end else begin
        pendValid_d = 1'b1;
        pendWrite_d = 1'b0;
      end
    end
    if ((anyStrobe && busy) || lowerDrop) error_d = 1'b1;
  end

  assign cpu_waitrequest = !((state_q == CWR) || (state_q == CRDY));
  assign cpu_readdata    = (state_q == CRDY) ? ramRdata_q : '0;
  assign MonDReg         = monDReg_q;
  assign monitor_ready   = ready_q;
  assign monitor_error   = error_q;

endmodule
